// File: rtl/pipelined_ripple_adder.sv
// -----------------------------------------------------------------------------
// pipelined_ripple_adder
//
// Ripple-carry adder/subtractor cut into STAGES register-separated slices of
// SW = WIDTH/STAGES bits each. Slice s works on bits [s*SW +: SW]. Its operand
// bits are skewed s register stages so they meet the registered carry from
// slice s-1. Finished slice sums are then deskewed so that all bits reach the
// output register together. A valid bit travels with every operand set.
// hold freezes every register. sum/cout/ovf only load when a valid set
// arrives, so bubbles leave the last result on the outputs.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (clears all state)
//   in_valid  in   a/b/cin/sub carry an operand set this cycle
//   hold      in   freeze the whole pipeline this cycle (inputs not sampled)
//   sub       in   0 = a + b + cin, 1 = a - b - cin
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in (add) / borrow-in (sub)
//   out_valid out  one-cycle strobe: sum/cout/ovf hold a new result
//   sum       out  WIDTH-bit result, modulo 2^WIDTH
//   cout      out  carry out of the MSB (sub: 1 = no borrow)
//   ovf       out  two's-complement signed overflow
//
// Latency: a set sampled on edge N appears after edge N+STAGES-1.
// -----------------------------------------------------------------------------
module pipelined_ripple_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             hold,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Illegal geometry must stop elaboration.
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_ripple_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    localparam int SW = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    // One slice of chained one-bit full-adder cells; returns {carry_out, sum}.
    function automatic logic [SW:0] ripple_slice(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          c_in
    );
        logic [SW-1:0] s;
        logic          c;
        c = c_in;
        for (int i = 0; i < SW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, s};
    endfunction

    // Subtraction is a + ~b + ~cin, so the inversion happens once at the input
    // and the delay lines only ever carry the effective operand.
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    assign b_eff_s   = b ^ {WIDTH{sub}};
    assign cin_eff_s = cin ^ sub;

    // Per-slice views, all aligned to the edge on which that slice computes.
    logic [SW-1:0] slice_a_s     [STAGES];
    logic [SW-1:0] slice_b_s     [STAGES];
    logic          slice_cin_s   [STAGES];
    logic [SW:0]   slice_res_s   [STAGES];
    logic [SW-1:0] aligned_sum_s [STAGES];
    logic          stage_valid_s [STAGES];

    assign stage_valid_s[0] = in_valid;

    for (genvar j = 0; j < STAGES; j++) begin : g_slice

        if (j == 0) begin : g_first
            assign slice_a_s[j]   = a[0 +: SW];
            assign slice_b_s[j]   = b_eff_s[0 +: SW];
            assign slice_cin_s[j] = cin_eff_s;
        end else begin : g_skew
            // Operand bits for slice j wait j stages for their carry.
            logic [2*SW-1:0] skew_q [j];

            // Operand skew shift register for this slice.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) begin
                        skew_q[k] <= {(2*SW){1'b0}};
                    end
                end else if (!hold) begin
                    skew_q[0] <= {a[j*SW +: SW], b_eff_s[j*SW +: SW]};
                    for (int k = 1; k < j; k++) begin
                        skew_q[k] <= skew_q[k-1];
                    end
                end
            end

            assign slice_a_s[j] = skew_q[j-1][2*SW-1:SW];
            assign slice_b_s[j] = skew_q[j-1][SW-1:0];
        end

        assign slice_res_s[j] = ripple_slice(slice_a_s[j], slice_b_s[j], slice_cin_s[j]);

        if (j < STAGES - 1) begin : g_inner
            logic          carry_q;
            logic          valid_q;
            // Finished low slices wait here until the top slice catches up.
            logic [SW-1:0] dsk_q [STAGES-1-j];

            // Inter-slice carry, valid bit and result deskew for slice j.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    carry_q <= 1'b0;
                    valid_q <= 1'b0;
                    for (int k = 0; k < STAGES - 1 - j; k++) begin
                        dsk_q[k] <= {SW{1'b0}};
                    end
                end else if (!hold) begin
                    carry_q  <= slice_res_s[j][SW];
                    valid_q  <= stage_valid_s[j];
                    dsk_q[0] <= slice_res_s[j][SW-1:0];
                    for (int k = 1; k < STAGES - 1 - j; k++) begin
                        dsk_q[k] <= dsk_q[k-1];
                    end
                end
            end

            assign slice_cin_s[j+1]   = carry_q;
            assign stage_valid_s[j+1] = valid_q;
            assign aligned_sum_s[j]   = dsk_q[STAGES-2-j];
        end else begin : g_last
            assign aligned_sum_s[j] = slice_res_s[j][SW-1:0];
        end
    end

    logic [WIDTH-1:0] full_sum_s;
    logic             final_cout_s;
    logic             msb_cin_s;

    // Reassemble the aligned slice sums into one word.
    always_comb begin
        full_sum_s = {WIDTH{1'b0}};
        for (int j = 0; j < STAGES; j++) begin
            full_sum_s[j*SW +: SW] = aligned_sum_s[j];
        end
    end

    assign final_cout_s = slice_res_s[STAGES-1][SW];
    // Carry into the MSB recovered from the MSB sum bit: s = x ^ y ^ c.
    assign msb_cin_s    = slice_a_s[STAGES-1][SW-1] ^ slice_b_s[STAGES-1][SW-1]
                        ^ slice_res_s[STAGES-1][SW-1];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Output next state: load only when a valid set reaches the end.
    always_comb begin
        out_valid_d = stage_valid_s[STAGES-1];
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (stage_valid_s[STAGES-1]) begin
            sum_d  = full_sum_s;
            cout_d = final_cout_s;
            ovf_d  = msb_cin_s ^ final_cout_s;
        end else begin
            sum_d  = sum_q;
            cout_d = cout_q;
            ovf_d  = ovf_q;
        end
    end

    // Output registers, frozen by hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (!hold) begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
